// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared dcache parameters and SHiP predictor types
package wt_cache_pkg;

  localparam int unsigned DCACHE_NUM_WORDS    = 16;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);

  localparam int unsigned SHIP_SIG_WIDTH = 8;
  localparam int unsigned SHIP_CTR_WIDTH = 3;
  localparam int unsigned SHIP_CTR_INIT  = 1;

  // Per-line predictor metadata: valid line, seen a hit since fill, owning signature
  typedef struct packed {
    logic                      valid;
    logic                      reused;
    logic [SHIP_SIG_WIDTH-1:0] sig;
  } ship_meta_t;

endpackage

// File: rtl/wt_dcache_ship_shct.sv
// rtl/wt_dcache_ship_shct.sv - signature history counter table with saturating inc/dec
module wt_dcache_ship_shct #(
  parameter int unsigned SIG_WIDTH = 8,
  parameter int unsigned CTR_WIDTH = 3,
  parameter int unsigned CTR_INIT  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [SIG_WIDTH-1:0] rd_sig_i,
  output logic [CTR_WIDTH-1:0] rd_ctr_o,
  input  logic                 inc_i,
  input  logic [SIG_WIDTH-1:0] inc_sig_i,
  input  logic                 dec_i,
  input  logic [SIG_WIDTH-1:0] dec_sig_i
);

  localparam int unsigned          NUM_ENTRIES = 2**SIG_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_RST     = CTR_WIDTH'(CTR_INIT);
  localparam logic [CTR_WIDTH-1:0] CTR_ONE     = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0] ctr_q [NUM_ENTRIES];
  logic                 collide;
  logic                 do_inc;
  logic                 do_dec;

  // Read returns the value before any update landing at the next edge
  assign rd_ctr_o = ctr_q[rd_sig_i];

  // An increment and decrement on the same entry cancel out
  assign collide = inc_i && dec_i && (inc_sig_i == dec_sig_i);
  assign do_inc  = inc_i && !collide;
  assign do_dec  = dec_i && !collide;

  // Counter table: reset/flush to CTR_INIT, otherwise saturating updates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else begin
      if (do_inc && (ctr_q[inc_sig_i] != CTR_MAX)) ctr_q[inc_sig_i] <= ctr_q[inc_sig_i] + CTR_ONE;
      if (do_dec && (ctr_q[dec_sig_i] != '0))      ctr_q[dec_sig_i] <= ctr_q[dec_sig_i] - CTR_ONE;
    end
  end

endmodule

// File: rtl/wt_dcache_ship_pred.sv
// rtl/wt_dcache_ship_pred.sv - SHiP-style reuse predictor giving SRRIP insertion hints
module wt_dcache_ship_pred
  import wt_cache_pkg::*;
#(
  parameter int unsigned SIG_WIDTH = SHIP_SIG_WIDTH,
  parameter int unsigned CTR_WIDTH = SHIP_CTR_WIDTH,
  parameter int unsigned CTR_INIT  = SHIP_CTR_INIT,
  parameter int unsigned NUM_SETS  = DCACHE_NUM_WORDS,
  parameter int unsigned NUM_WAYS  = DCACHE_SET_ASSOC
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           query_i,
  input  logic [SIG_WIDTH-1:0]           query_sig_i,
  output logic                           pred_valid_o,
  output logic [1:0]                     pred_result_o,
  input  logic                           fill_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0] fill_idx_i,
  input  logic [$clog2(NUM_WAYS)-1:0]    fill_way_i,
  input  logic [SIG_WIDTH-1:0]           fill_sig_i,
  input  logic                           hit_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i,
  input  logic [$clog2(NUM_WAYS)-1:0]    hit_way_i,
  input  logic                           inval_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0] inval_idx_i,
  input  logic [$clog2(NUM_WAYS)-1:0]    inval_way_i
);

  ship_meta_t           meta_q [NUM_SETS][NUM_WAYS];
  ship_meta_t           fill_old;
  ship_meta_t           hit_meta;
  logic                 hit_on_fill;
  logic                 inval_on_fill;
  logic                 hit_ok;
  logic                 inval_ok;
  logic                 dead_evict;
  logic [CTR_WIDTH-1:0] rd_ctr;

  assign fill_old = meta_q[fill_idx_i][fill_way_i];
  assign hit_meta = meta_q[hit_idx_i][hit_way_i];

  // A fill to the same line overrides a concurrent hit or invalidation
  assign hit_on_fill   = fill_i && (hit_idx_i == fill_idx_i) && (hit_way_i == fill_way_i);
  assign inval_on_fill = fill_i && (inval_idx_i == fill_idx_i) && (inval_way_i == fill_way_i);
  assign hit_ok        = hit_i && hit_meta.valid && !hit_on_fill;
  assign inval_ok      = inval_i && !inval_on_fill;

  // Evicting a valid line that never hit trains its signature towards dead
  assign dead_evict = fill_i && fill_old.valid && !fill_old.reused;

  wt_dcache_ship_shct #(
    .SIG_WIDTH (SIG_WIDTH),
    .CTR_WIDTH (CTR_WIDTH),
    .CTR_INIT  (CTR_INIT)
  ) u_shct (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .rd_sig_i  (query_sig_i),
    .rd_ctr_o  (rd_ctr),
    .inc_i     (hit_ok),
    .inc_sig_i (hit_meta.sig),
    .dec_i     (dead_evict),
    .dec_sig_i (fill_old.sig)
  );

  // Line metadata: hit marks reuse, inval clears valid, fill is written last so it wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NUM_SETS; s++)
        for (int unsigned w = 0; w < NUM_WAYS; w++) meta_q[s][w] <= '0;
    end else if (flush_i) begin
      for (int unsigned s = 0; s < NUM_SETS; s++)
        for (int unsigned w = 0; w < NUM_WAYS; w++) meta_q[s][w] <= '0;
    end else begin
      if (hit_ok)   meta_q[hit_idx_i][hit_way_i].reused    <= 1'b1;
      if (inval_ok) meta_q[inval_idx_i][inval_way_i].valid <= 1'b0;
      if (fill_i)   meta_q[fill_idx_i][fill_way_i]         <= '{valid: 1'b1, reused: 1'b0, sig: fill_sig_i};
    end
  end

  // Prediction register: one-cycle valid pulse, result held until the next query
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_o  <= 1'b0;
      pred_result_o <= 2'd2;
    end else if (flush_i) begin
      pred_valid_o  <= 1'b0;
      pred_result_o <= 2'd2;
    end else begin
      pred_valid_o <= query_i;
      if (query_i) pred_result_o <= (rd_ctr == '0) ? 2'd3 : 2'd2;
    end
  end

endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// tb/tb_wt_dcache_ship_pred.sv - directed self-checking bench for wt_dcache_ship_pred
module tb_wt_dcache_ship_pred;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       query_i;
  logic [7:0] query_sig_i;
  logic       pred_valid_o;
  logic [1:0] pred_result_o;
  logic       fill_i;
  logic [3:0] fill_idx_i;
  logic [1:0] fill_way_i;
  logic [7:0] fill_sig_i;
  logic       hit_i;
  logic [3:0] hit_idx_i;
  logic [1:0] hit_way_i;
  logic       inval_i;
  logic [3:0] inval_idx_i;
  logic [1:0] inval_way_i;

  int total = 0;
  int bad   = 0;

  wt_dcache_ship_pred u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .query_i       (query_i),
    .query_sig_i   (query_sig_i),
    .pred_valid_o  (pred_valid_o),
    .pred_result_o (pred_result_o),
    .fill_i        (fill_i),
    .fill_idx_i    (fill_idx_i),
    .fill_way_i    (fill_way_i),
    .fill_sig_i    (fill_sig_i),
    .hit_i         (hit_i),
    .hit_idx_i     (hit_idx_i),
    .hit_way_i     (hit_way_i),
    .inval_i       (inval_i),
    .inval_idx_i   (inval_idx_i),
    .inval_way_i   (inval_way_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    flush_i = 0; query_i = 0; query_sig_i = 0;
    fill_i = 0; fill_idx_i = 0; fill_way_i = 0; fill_sig_i = 0;
    hit_i = 0; hit_idx_i = 0; hit_way_i = 0;
    inval_i = 0; inval_idx_i = 0; inval_way_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic do_fill(input logic [3:0] idx, input logic [1:0] way, input logic [7:0] sig);
    fill_i = 1; fill_idx_i = idx; fill_way_i = way; fill_sig_i = sig;
  endtask

  task automatic do_hit(input logic [3:0] idx, input logic [1:0] way);
    hit_i = 1; hit_idx_i = idx; hit_way_i = way;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 0;
    #12;
    total++; if (pred_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", pred_valid_o); end
    total++; if (pred_result_o !== 2'd2) begin bad++; $display("FAIL reset_result got=%0d exp=2", pred_result_o); end
    total++; if (u_dut.u_shct.ctr_q[8'h12] !== 3'd1) begin bad++; $display("FAIL reset_shct got=%0d exp=1", u_dut.u_shct.ctr_q[8'h12]); end
    @(negedge clk_i);
    rst_ni = 1;
    tick();
  endtask

  task automatic test_query();
    query_i = 1; query_sig_i = 8'h12;
    tick();
    total++; if (pred_valid_o !== 1'b1) begin bad++; $display("FAIL query_valid got=%0d exp=1", pred_valid_o); end
    total++; if (pred_result_o !== 2'd2) begin bad++; $display("FAIL query_result got=%0d exp=2", pred_result_o); end
    tick();
    total++; if (pred_valid_o !== 1'b0) begin bad++; $display("FAIL query_pulse got=%0d exp=0", pred_valid_o); end
  endtask

  task automatic test_dead_evict();
    do_fill(4'd5, 2'd2, 8'h12); tick();
    do_fill(4'd5, 2'd2, 8'h56); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h12] !== 3'd0) begin bad++; $display("FAIL dead_dec got=%0d exp=0", u_dut.u_shct.ctr_q[8'h12]); end
    query_i = 1; query_sig_i = 8'h12; tick();
    total++; if (pred_valid_o !== 1'b1 || pred_result_o !== 2'd3) begin bad++; $display("FAIL dead_query got=%0d/%0d exp=1/3", pred_valid_o, pred_result_o); end
    tick();
    total++; if (pred_valid_o !== 1'b0 || pred_result_o !== 2'd3) begin bad++; $display("FAIL dead_hold got=%0d/%0d exp=0/3", pred_valid_o, pred_result_o); end
  endtask

  task automatic test_saturate();
    do_fill(4'd7, 2'd0, 8'h34); tick();
    do_hit(4'd7, 2'd0); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd2) begin bad++; $display("FAIL hit_inc got=%0d exp=2", u_dut.u_shct.ctr_q[8'h34]); end
    for (int i = 0; i < 6; i++) begin do_hit(4'd7, 2'd0); tick(); end
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd7) begin bad++; $display("FAIL sat7 got=%0d exp=7", u_dut.u_shct.ctr_q[8'h34]); end
    do_hit(4'd7, 2'd0); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd7) begin bad++; $display("FAIL sat8 got=%0d exp=7", u_dut.u_shct.ctr_q[8'h34]); end
  endtask

  task automatic test_collision();
    do_fill(4'd9, 2'd0, 8'h34); tick();
    do_fill(4'd9, 2'd0, 8'h41); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd6) begin bad++; $display("FAIL pre_coll got=%0d exp=6", u_dut.u_shct.ctr_q[8'h34]); end
    do_fill(4'd8, 2'd3, 8'h34); tick();
    do_hit(4'd7, 2'd0); do_fill(4'd8, 2'd3, 8'h40); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd6) begin bad++; $display("FAIL coll_net got=%0d exp=6", u_dut.u_shct.ctr_q[8'h34]); end
    do_hit(4'd7, 2'd0); do_fill(4'd9, 2'd0, 8'h42); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd7) begin bad++; $display("FAIL dist_inc got=%0d exp=7", u_dut.u_shct.ctr_q[8'h34]); end
    total++; if (u_dut.u_shct.ctr_q[8'h41] !== 3'd0) begin bad++; $display("FAIL dist_dec got=%0d exp=0", u_dut.u_shct.ctr_q[8'h41]); end
  endtask

  task automatic test_fill_hit_same();
    do_fill(4'd3, 2'd1, 8'h60); tick();
    do_fill(4'd3, 2'd1, 8'h50); do_hit(4'd3, 2'd1); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h60] !== 3'd0) begin bad++; $display("FAIL fh_drop got=%0d exp=0", u_dut.u_shct.ctr_q[8'h60]); end
    total++; if (u_dut.meta_q[3][1].reused !== 1'b0) begin bad++; $display("FAIL fh_reused got=%0d exp=0", u_dut.meta_q[3][1].reused); end
    total++; if (u_dut.u_shct.ctr_q[8'h50] !== 3'd1) begin bad++; $display("FAIL fh_newsig got=%0d exp=1", u_dut.u_shct.ctr_q[8'h50]); end
  endtask

  task automatic test_inval();
    do_fill(4'd10, 2'd1, 8'h70); tick();
    inval_i = 1; inval_idx_i = 4'd10; inval_way_i = 2'd1; tick();
    do_hit(4'd10, 2'd1); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h70] !== 3'd1) begin bad++; $display("FAIL inval_hit got=%0d exp=1", u_dut.u_shct.ctr_q[8'h70]); end
    do_fill(4'd10, 2'd1, 8'h72); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h70] !== 3'd1) begin bad++; $display("FAIL inval_nodec got=%0d exp=1", u_dut.u_shct.ctr_q[8'h70]); end
    do_fill(4'd11, 2'd0, 8'h71); inval_i = 1; inval_idx_i = 4'd11; inval_way_i = 2'd0; tick();
    do_hit(4'd11, 2'd0); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h71] !== 3'd2) begin bad++; $display("FAIL fill_vs_inval got=%0d exp=2", u_dut.u_shct.ctr_q[8'h71]); end
  endtask

  task automatic test_flush();
    query_i = 1; query_sig_i = 8'h12; tick();
    total++; if (pred_result_o !== 2'd3) begin bad++; $display("FAIL preflush_result got=%0d exp=3", pred_result_o); end
    flush_i = 1; query_i = 1; query_sig_i = 8'h12; do_hit(4'd7, 2'd0); tick();
    total++; if (pred_valid_o !== 1'b0 || pred_result_o !== 2'd2) begin bad++; $display("FAIL flush_pred got=%0d/%0d exp=0/2", pred_valid_o, pred_result_o); end
    total++; if (u_dut.u_shct.ctr_q[8'h12] !== 3'd1 || u_dut.u_shct.ctr_q[8'h34] !== 3'd1) begin bad++; $display("FAIL flush_shct got=%0d/%0d exp=1/1", u_dut.u_shct.ctr_q[8'h12], u_dut.u_shct.ctr_q[8'h34]); end
    do_hit(4'd7, 2'd0); tick();
    total++; if (u_dut.u_shct.ctr_q[8'h34] !== 3'd1) begin bad++; $display("FAIL flush_hit got=%0d exp=1", u_dut.u_shct.ctr_q[8'h34]); end
  endtask

  task automatic test_async_reset();
    query_i = 1; query_sig_i = 8'h20; tick();
    total++; if (pred_valid_o !== 1'b1) begin bad++; $display("FAIL ar_valid got=%0d exp=1", pred_valid_o); end
    rst_ni = 0;
    #1;
    total++; if (pred_valid_o !== 1'b0) begin bad++; $display("FAIL ar_drop got=%0d exp=0", pred_valid_o); end
    @(negedge clk_i);
    rst_ni = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_query();
    test_dead_evict();
    test_saturate();
    test_collision();
    test_fill_hit_same();
    test_inval();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
